// File: rtl/demux_pkg.sv
// Shared definitions for the demux_stream block: FSM state encoding,
// the drop counter width, and a saturating increment helper.
package demux_pkg;

    // Packet-level routing state.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DROP  = 2'd2
    } demux_state_e;

    // Width of the dropped-packet counter.
    localparam int DROP_CNT_W = 8;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] value);
        return (&value) ? value : value + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/demux_out_reg.sv
// Single output register stage shared by all channels of demux_stream.
// Holds one beat (data, last), its valid bit and the one-hot channel it
// is presented on. A new beat may load in the same cycle the held beat
// drains, which gives one beat per cycle while the consumer is ready.
module demux_out_reg
    import demux_pkg::*;
#(
    parameter int OUTS = 5,
    parameter int DW   = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [DW-1:0]   load_data,
    input  logic            load_last,
    input  logic [OUTS-1:0] load_dest,
    input  logic [OUTS-1:0] out_ready,
    output logic [DW-1:0]   out_data,
    output logic            out_last,
    output logic [OUTS-1:0] out_valid,
    output logic            full,
    output logic            drain
);

    logic            valid_q;
    logic [OUTS-1:0] dest_q;

    // Present the held beat only on its own channel; detect the handshake.
    always_comb begin
        out_valid = valid_q ? dest_q : '0;
        full      = valid_q;
        drain     = valid_q && |(dest_q & out_ready);
    end

    // Load a new beat, or clear valid once the held beat has been taken.
    // NOTE: the payload is reset along with the control bits because
    // out_data/out_last are observable right after reset and must read 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            dest_q   <= '0;
            out_data <= '0;
            out_last <= 1'b0;
        end else if (load) begin
            valid_q  <= 1'b1;
            dest_q   <= load_dest;
            out_data <= load_data;
            out_last <= load_last;
        end else if (drain) begin
            valid_q  <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_stream.sv
// Packet stream demultiplexer: the first beat of each packet selects one of
// OUTS output channels via sel; the rest of the packet follows that channel
// regardless of later sel values. Packets addressed to a non-existent
// channel (sel >= OUTS) are accepted and silently discarded.
// Optional error reporting (drop_err pulse, saturating drop_cnt) is enabled
// by defining DEMUX_STREAM_ERR_EN.
module demux_stream
    import demux_pkg::*;
#(
    parameter int OUTS = 5,
    parameter int DW   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DW-1:0]            in_data,
    input  logic                     in_valid,
    input  logic                     in_last,
    input  logic [$clog2(OUTS)-1:0]  sel,
    output logic                     in_ready,
    output logic [DW-1:0]            out_data,
    output logic                     out_last,
    output logic [OUTS-1:0]          out_valid,
    input  logic [OUTS-1:0]          out_ready
`ifdef DEMUX_STREAM_ERR_EN
    ,
    output logic                     drop_err,
    output logic [DROP_CNT_W-1:0]    drop_cnt
`endif
);

    localparam int SW = $clog2(OUTS);

    demux_state_e    state;
    logic [SW-1:0]   dest;
    logic            run;

    logic            first_beat;
    logic            sel_drop;
    logic            drop_beat;
    logic            accept;
    logic            load;
    logic [SW-1:0]   route_sel;
    logic [OUTS-1:0] route_onehot;
    logic            out_full;
    logic            out_drain;

    // Handshake and routing decisions for the beat on the input this cycle.
    // NOTE: every signal here is assigned before any branch can skip it, so
    // the block stays purely combinational and no latch is inferred.
    always_comb begin
        first_beat = (state == IDLE);
        sel_drop   = (32'(sel) >= 32'(OUTS));
        drop_beat  = (state == DROP) || (first_beat && sel_drop);
        route_sel  = first_beat ? sel : dest;
        // Dropped beats never touch the output register, so they are always
        // accepted; routed beats need the register empty or draining.
        in_ready   = run && (drop_beat || !out_full || out_drain);
        accept     = in_valid && in_ready;
        load       = accept && !drop_beat;
    end

    // One-hot form of the channel the current beat is routed to.
    always_comb begin
        route_onehot = '0;
        for (int k = 0; k < OUTS; k++) begin
            route_onehot[k] = (int'(route_sel) == k);
        end
    end

    // Holds in_ready low during reset and raises it from the first clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    // Packet FSM: latch the destination on the first beat, track the packet
    // until its last beat. A reset mid-packet returns to IDLE, discarding it.
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            dest  <= '0;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    dest <= sel;
                    if (!in_last) begin
                        state <= sel_drop ? DROP : ROUTE;
                    end
                end
                ROUTE, DROP: begin
                    if (in_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    demux_out_reg #(
        .OUTS (OUTS),
        .DW   (DW)
    ) u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_data (in_data),
        .load_last (in_last),
        .load_dest (route_onehot),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .full      (out_full),
        .drain     (out_drain)
    );

`ifdef DEMUX_STREAM_ERR_EN
    // Pulse on every accepted first beat of a dropped packet and count them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_err <= 1'b0;
            drop_cnt <= '0;
        end else begin
            drop_err <= accept && first_beat && sel_drop;
            if (accept && first_beat && sel_drop) begin
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench for demux_stream (OUTS=5, DW=8). Stimulus pushes the
// expected output beats into a queue; an independent monitor pops and
// compares whenever a channel handshake is presented.
// Define DEMUX_STREAM_ERR_EN to also exercise drop_err / drop_cnt.
module tb_demux_stream;
    import demux_pkg::*;

    localparam int OUTS = 5;
    localparam int DW   = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [DW-1:0]   in_data;
    logic            in_valid;
    logic            in_last;
    logic [2:0]      sel;
    logic            in_ready;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic [OUTS-1:0] out_valid;
    logic [OUTS-1:0] out_ready;
`ifdef DEMUX_STREAM_ERR_EN
    logic                  drop_err;
    logic [DROP_CNT_W-1:0] drop_cnt;
`endif

    demux_stream #(
        .OUTS (OUTS),
        .DW   (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .sel       (sel),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DEMUX_STREAM_ERR_EN
        ,
        .drop_err  (drop_err),
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int           ch;
        logic [DW-1:0] data;
        logic         last;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_beat;
    int    checks = 0;
    int    passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compare every output handshake against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                for (int k = 0; k < OUTS; k++) begin
                    if (out_valid[k] && out_ready[k]) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_beat_channel", k, 32'hFFFF_FFFF);
                        end else begin
                            mon_beat = exp_q.pop_front();
                            check("mon_channel", k, mon_beat.ch);
                            check("mon_data", out_data, mon_beat.data);
                            check("mon_last", out_last, mon_beat.last);
                            check("mon_onehot", out_valid, 32'(1) << mon_beat.ch);
                        end
                    end
                end
            end
        end
    end

    // Drive one beat and wait (bounded) for acceptance; ch < 0 means dropped.
    // Called just after a falling edge; returns on the falling edge after
    // the accepting rising edge.
    task automatic send(input logic [DW-1:0] d, input logic l, input logic [2:0] s, input int ch);
        int n = 0;
        in_data  = d;
        in_last  = l;
        sel      = s;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", in_ready, 1);
        end else begin
            if (ch >= 0) exp_q.push_back('{ch, d, l});
            @(posedge clk);
        end
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end

    initial begin
        int n;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        sel       = '0;
        out_ready = '1;

        // Reset state
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_in_ready", in_ready, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("in_ready_before_first_edge", in_ready, 0);
        @(negedge clk);
        #1;
        check("in_ready_after_first_edge", in_ready, 1);

        // 3-beat packet to channel 2, consumer always ready
        send(8'h11, 1'b0, 3'd2, 2);
        #1 check("pkt2_b1_valid", out_valid, 5'b00100);
        send(8'h22, 1'b0, 3'd2, 2);
        #1 check("pkt2_b2_valid", out_valid, 5'b00100);
        send(8'h33, 1'b1, 3'd2, 2);
        #1 check("pkt2_b3_valid", out_valid, 5'b00100);
        check("pkt2_b3_last", out_last, 1);
        idle_cycle();
        check("pkt2_drained", out_valid, 0);

        // Same packet with channel 2 back-pressured after the first beat
        out_ready = 5'b11011;
        send(8'h11, 1'b0, 3'd2, 2);
        in_data  = 8'h22;
        in_last  = 1'b0;
        sel      = 3'd2;
        in_valid = 1'b1;
        #1;
        check("stall_in_ready", in_ready, 0);
        check("stall_data", out_data, 8'h11);
        repeat (2) begin
            @(negedge clk);
            #1;
            check("stall_hold_in_ready", in_ready, 0);
            check("stall_hold_data", out_data, 8'h11);
            check("stall_hold_valid", out_valid, 5'b00100);
        end
        @(negedge clk);
        out_ready = '1;
        #1 check("stall_release_in_ready", in_ready, 1);
        send(8'h22, 1'b0, 3'd2, 2);
        send(8'h33, 1'b1, 3'd2, 2);
        idle_cycle();

        // 2-beat packet to non-existent channel 6 is dropped
        send(8'h61, 1'b0, 3'd6, -1);
        #1 check("drop_b1_valid", out_valid, 0);
`ifdef DEMUX_STREAM_ERR_EN
        check("drop_err_pulse", drop_err, 1);
`endif
        send(8'h62, 1'b1, 3'd6, -1);
        #1 check("drop_b2_valid", out_valid, 0);
`ifdef DEMUX_STREAM_ERR_EN
        check("drop_err_single", drop_err, 0);
        check("drop_cnt_one", drop_cnt, 1);
`endif

        // Boundaries: sel == OUTS drops, sel == OUTS-1 routes (single beats)
        send(8'h77, 1'b1, 3'd5, -1);
        #1 check("drop_sel5_valid", out_valid, 0);
`ifdef DEMUX_STREAM_ERR_EN
        check("drop_cnt_two", drop_cnt, 2);
`endif
        send(8'h88, 1'b1, 3'd4, 4);
        #1 check("route_sel4_valid", out_valid, 5'b10000);
        idle_cycle();

        // sel changes mid-packet: routing stays on channel 1
        send(8'hA1, 1'b0, 3'd1, 1);
        send(8'hA2, 1'b0, 3'd3, 1);
        #1 check("midpkt_sel_ignored", out_valid, 5'b00010);
        send(8'hA3, 1'b1, 3'd3, 1);
        idle_cycle();

        // Reset after the first beat of a sel=4 packet
        send(8'h44, 1'b0, 3'd4, 4);
        #3;
        reset = 1'b1;
        #1;
        check("midpkt_reset_valid", out_valid, 0);
        check("midpkt_reset_in_ready", in_ready, 0);
`ifdef DEMUX_STREAM_ERR_EN
        check("midpkt_reset_drop_cnt", drop_cnt, 0);
`endif
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1 check("post_reset_in_ready", in_ready, 1);
        send(8'h55, 1'b1, 3'd0, 0);
        #1 check("post_reset_new_packet", out_valid, 5'b00001);
        idle_cycle();

`ifdef DEMUX_STREAM_ERR_EN
        // 256 dropped single-beat packets saturate the counter
        for (int i = 0; i < 256; i++) begin
            send(8'(i), 1'b1, 3'd7, -1);
        end
        #1 check("drop_cnt_saturate", drop_cnt, 255);
        idle_cycle();
`endif

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        #3;
        check("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/demux_stream.md
DEMUX_STREAM -- requirements
Module: demux_stream

Interface
REQ-001 SHALL have parameter OUTS, default 5: number of output channels, legal range 2..16.
REQ-002 SHALL have parameter DW, default 8: data width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_data, input, DW bits: input beat payload.
REQ-006 SHALL have port in_valid, input, 1 bit: input beat present.
REQ-007 SHALL have port in_last, input, 1 bit: marks the final beat of a packet.
REQ-008 SHALL have port sel, input, $clog2(OUTS) bits: destination channel, sampled on the first beat of a packet only.
REQ-009 SHALL have port in_ready, output, 1 bit: block accepts the beat this cycle.
REQ-010 SHALL have port out_data, output, DW bits: registered payload, shared by all channels.
REQ-011 SHALL have port out_last, output, 1 bit: registered last flag.
REQ-012 SHALL have port out_valid, output, OUTS bits: one-hot; bit k set means channel k holds a beat.
REQ-013 SHALL have port out_ready, input, OUTS bits: per-channel consumer ready.

Function
REQ-014 SHALL transfer an input beat only when in_valid and in_ready are both high, and an output beat on channel k only when out_valid[k] and out_ready[k] are both high.
REQ-015 SHALL hold one output register stage with 1-cycle latency from input acceptance to out_valid.
REQ-016 SHALL drive in_ready = ~out_full | out_ready[dest], so full throughput (1 beat/cycle) is sustained while the consumer is ready.
REQ-017 SHALL hold out_data, out_last and out_valid stable while out_valid[dest] is high and out_ready[dest] is low.
REQ-018 SHALL implement an FSM with states IDLE, ROUTE and DROP.
REQ-019 SHALL, in IDLE on an accepted beat, latch dest = sel; a beat with in_last high stays in IDLE, otherwise the FSM goes to ROUTE when sel < OUTS and to DROP when sel >= OUTS.
REQ-020 SHALL, in ROUTE, ignore sel, route every beat to the latched dest, and return to IDLE on the accepted beat with in_last high.
REQ-021 SHALL, for packets with sel >= OUTS (including single-beat packets), accept and discard every beat with in_ready held at 1 and out_valid left unchanged; DROP returns to IDLE on the accepted last beat.
REQ-022 SHALL keep at most one bit of out_valid set at any time.
REQ-023 SHALL make a change of sel in mid-packet have no effect on routing.

Reset
REQ-024 SHALL, while reset is high, asynchronously force: FSM = IDLE, out_valid = 0, out_last = 0, out_data = 0, dest = 0, and in_ready = 0.
REQ-025 SHALL, after reset deasserts, raise in_ready from the first clk edge.
REQ-026 SHALL, on reset in mid-packet, discard the partial packet and start the next accepted beat as a new first beat.

Configuration
REQ-027 SHALL, when macro DEMUX_STREAM_ERR_EN is defined, add output drop_err (1 bit, a 1-cycle pulse on each accepted first beat with sel >= OUTS) and output drop_cnt (8 bits, saturating count of dropped packets, reset to 0).
REQ-028 SHALL, when DEMUX_STREAM_ERR_EN is undefined, omit both ports with no change to the drop behaviour.

Structure
REQ-029 SHALL place the FSM state typedef (IDLE=0, ROUTE=1, DROP=2) and the drop_cnt width constant (8) in shared package demux_pkg.
REQ-030 SHALL implement the output register stage as sub-module demux_out_reg, which holds data, last, a valid bit and a one-hot destination.

Verification
REQ-031 SHALL cover: OUTS=5, DW=8, all out_ready=1; 3-beat packet sel=2, data 0x11/0x22/0x33, last on the 3rd beat -> out_valid=5'b00100 for 3 consecutive cycles, each 1 cycle after acceptance, out_last on the 3rd beat.
REQ-032 SHALL cover: out_ready[2]=0 during the packet in REQ-031 -> in_ready=0 after the first beat; out_data holds 0x11 until out_ready[2]=1.
REQ-033 SHALL cover: sel=6, 2-beat packet -> both beats accepted, out_valid stays 0; with the macro, drop_err pulses once and drop_cnt=1.
REQ-034 SHALL cover: sel changes 1->3 on beat 2 of a packet routed to channel 1 -> all beats on channel 1.
REQ-035 SHALL cover: reset asserted after beat 1 of a sel=4 packet -> out_valid=0 immediately; the next beat with sel=0 and in_last high -> out_valid=5'b00001.
REQ-036 SHALL cover: 256 dropped packets with the macro -> drop_cnt saturates at 255.
